msg_framer: RTL and testbench

- Parametrised successor to the per-unit hard-coded status messaging logic.
- Accepts event requests (fault, pick, drop) from any section unit and queues them in an internal FIFO.
- Serialises each request into a complete ASCII message and presents it byte-by-byte over a valid/ready handshake to the UART transmitter.
- Enforces a programmable inter-byte gap, and reports status and counters to the LED and debug logic.

---
 rtl/msg_framer.sv | 215 +++++++++++++++++++++
 tb/tb_msg_framer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msg_framer.sv
// Event-to-ASCII status message framer: queues fault/pick/drop events and streams
// each one as a complete text message over a valid/ready byte interface.
module msg_framer #(
    parameter int BYTE_GAP    = 4340,
    parameter int ID_W        = 4,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                           clk_50M,
    input  logic                           rst,
    input  logic                           ev_valid,
    output logic                           ev_ready,
    input  logic [1:0]                     ev_type,
    input  logic [1:0]                     ev_unit,
    input  logic [ID_W-1:0]                ev_id,
    output logic [7:0]                     tx_data,
    output logic                           tx_valid,
    input  logic                           tx_ready,
    output logic                           busy,
    output logic                           msg_done,
    output logic [$clog2(QUEUE_DEPTH):0]   queue_level,
    output logic [7:0]                     msg_count,
    output logic [7:0]                     rej_count
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int EV_W  = 4 + ID_W;
    localparam int GAP_W = (BYTE_GAP < 2) ? 1 : $clog2(BYTE_GAP);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((BYTE_GAP == 0) ? 0 : BYTE_GAP - 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(QUEUE_DEPTH);
    localparam bit               NO_GAP   = (BYTE_GAP == 0);

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    function automatic logic [7:0] hex_digit(input logic [ID_W-1:0] id);
        logic [3:0] v;
        v = 4'(id);
        return (v < 4'd10) ? (8'h30 + {4'h0, v}) : (8'h37 + {4'h0, v});
    endfunction

    function automatic logic [3:0] last_idx(input logic [1:0] typ);
        case (typ)
            2'd0:    return 4'd10;
            2'd1:    return 4'd11;
            default: return 4'd8;
        endcase
    endfunction

    // All three formats share the "XYM-USU-" prefix; they differ only from byte 8 on.
    function automatic logic [7:0] msg_byte(input logic [1:0] typ, input logic [1:0] unit,
                                            input logic [ID_W-1:0] id, input logic [3:0] idx);
        logic [7:0] u;
        logic [7:0] b;
        u = (unit == 2'd0) ? 8'h45 : (unit == 2'd1) ? 8'h43 : 8'h52;
        case (idx)
            4'd0:    b = (typ == 2'd0) ? 8'h46 : 8'h42;
            4'd1:    b = (typ == 2'd0) ? 8'h49 : (typ == 2'd1) ? 8'h50 : 8'h44;
            4'd2:    b = 8'h4D;
            4'd3:    b = 8'h2D;
            4'd4:    b = u;
            4'd5:    b = 8'h53;
            4'd6:    b = 8'h55;
            4'd7:    b = 8'h2D;
            4'd8:    b = (typ == 2'd0) ? hex_digit(id) : (typ == 2'd1) ? 8'h42 : 8'h23;
            4'd9:    b = (typ == 2'd1) ? hex_digit(id) : 8'h2D;
            4'd10:   b = (typ == 2'd1) ? 8'h2D : 8'h23;
            default: b = 8'h23;
        endcase
        return b;
    endfunction

    // Event FIFO
    logic [EV_W-1:0]  fifo_mem [QUEUE_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [LVL_W-1:0] level_q, level_d;
    logic             ev_ready_q;
    logic             accept, reserved, push, pop;
    logic [EV_W-1:0]  head;

    // Framer state
    state_t           state_q, state_d;
    logic [EV_W-1:0]  cur_q, cur_d;
    logic [3:0]       idx_q, idx_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             ended_q, ended_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             msg_done_q, msg_done_d;
    logic [7:0]       msg_count_q, rej_count_q;

    logic [1:0]       cur_type, cur_unit, head_type, head_unit;
    logic [ID_W-1:0]  cur_id, head_id;

    assign accept   = ev_valid && ev_ready_q;
    assign reserved = (ev_type == 2'd3) || (ev_unit == 2'd3);
    assign push     = accept && !reserved;
    assign pop      = (state_q == IDLE) && (level_q != '0);
    assign head     = fifo_mem[rd_ptr_q];
    assign level_d  = level_q + LVL_W'(push) - LVL_W'(pop);

    assign head_type = head[EV_W-1 -: 2];
    assign head_unit = head[EV_W-3 -: 2];
    assign head_id   = head[ID_W-1:0];
    assign cur_type  = cur_q[EV_W-1 -: 2];
    assign cur_unit  = cur_q[EV_W-3 -: 2];
    assign cur_id    = cur_q[ID_W-1:0];

    always_ff @(posedge clk_50M) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {ev_type, ev_unit, ev_id};
        end
    end

    // ev_ready is registered from the next occupancy, so a full FIFO refuses a push
    // even when the framer pops in the same cycle.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            ev_ready_q  <= 1'b1;
            rej_count_q <= 8'd0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            level_q    <= level_d;
            ev_ready_q <= (level_d != FULL_LVL);
            if (accept && reserved && rej_count_q != 8'hFF) begin
                rej_count_q <= rej_count_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        idx_d      = idx_q;
        gap_d      = gap_q;
        ended_d    = ended_q;
        tx_data_d  = tx_data_q;
        msg_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    cur_d     = head;
                    idx_d     = 4'd0;
                    tx_data_d = msg_byte(head_type, head_unit, head_id, 4'd0);
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    gap_d = '0;
                    if (idx_q == last_idx(cur_type)) begin
                        msg_done_d = 1'b1;
                        ended_d    = 1'b1;
                        state_d    = NO_GAP ? IDLE : GAP;
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        ended_d = 1'b0;
                        if (NO_GAP) begin
                            tx_data_d = msg_byte(cur_type, cur_unit, cur_id, idx_q + 4'd1);
                        end else begin
                            state_d = GAP;
                        end
                    end
                end
            end
            GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (ended_q) begin
                        state_d = IDLE;
                    end else begin
                        tx_data_d = msg_byte(cur_type, cur_unit, cur_id, idx_q);
                        state_d   = SEND;
                    end
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            idx_q       <= 4'd0;
            gap_q       <= '0;
            ended_q     <= 1'b0;
            tx_data_q   <= 8'd0;
            msg_done_q  <= 1'b0;
            msg_count_q <= 8'd0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            idx_q      <= idx_d;
            gap_q      <= gap_d;
            ended_q    <= ended_d;
            tx_data_q  <= tx_data_d;
            msg_done_q <= msg_done_d;
            if (msg_done_d) msg_count_q <= msg_count_q + 8'd1;
        end
    end

    assign ev_ready    = ev_ready_q;
    assign tx_data     = tx_data_q;
    assign tx_valid    = (state_q == SEND);
    assign busy        = (state_q != IDLE) || (level_q != '0);
    assign msg_done    = msg_done_q;
    assign queue_level = level_q;
    assign msg_count   = msg_count_q;
    assign rej_count   = rej_count_q;

endmodule

// File: tb/tb_msg_framer.sv
// Scoreboard bench for msg_framer: expected message bytes are queued when an event
// is issued and a negedge monitor compares every byte handshake against them.
module tb_msg_framer;

    localparam int TMO = 2000;

    logic       clk_50M;
    logic       rst;
    logic       ev_valid;
    logic       ev_ready;
    logic [1:0] ev_type;
    logic [1:0] ev_unit;
    logic [3:0] ev_id;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       busy;
    logic       msg_done;
    logic [2:0] queue_level;
    logic [7:0] msg_count;
    logic [7:0] rej_count;

    msg_framer #(.BYTE_GAP(2), .ID_W(4), .QUEUE_DEPTH(4)) dut (
        .clk_50M     (clk_50M),
        .rst         (rst),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_type     (ev_type),
        .ev_unit     (ev_unit),
        .ev_id       (ev_id),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .busy        (busy),
        .msg_done    (msg_done),
        .queue_level (queue_level),
        .msg_count   (msg_count),
        .rej_count   (rej_count)
    );

    initial clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         exp_len[$];
    int         hs_cyc[$];
    int         hs_total = 0;
    int         cyc = 0;
    int         bytes_in_msg = 0;
    int         mon_len;
    logic [7:0] mon_exp;

    always @(posedge clk_50M) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: one line per byte handshake and per completed message.
    always @(negedge clk_50M) begin
        if (rst) begin
            bytes_in_msg = 0;
        end else begin
            if (msg_done) begin
                if (exp_len.size() == 0) begin
                    check("msg_done_unexpected", 1, 0);
                end else begin
                    mon_len = exp_len.pop_front();
                    check("msg_length", bytes_in_msg, mon_len);
                end
                bytes_in_msg = 0;
            end
            if (tx_valid && tx_ready) begin
                if (exp_q.size() == 0) begin
                    check("tx_byte_unexpected", int'(tx_data), 256);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("tx_byte", int'(tx_data), int'(mon_exp));
                end
                bytes_in_msg++;
                hs_total++;
                hs_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk_50M);
        #1;
    endtask

    task automatic push_ev(input logic [1:0] t, input logic [1:0] u, input logic [3:0] id,
                           input string m);
        int n;
        n = 0;
        ev_valid = 1'b1;
        ev_type  = t;
        ev_unit  = u;
        ev_id    = id;
        while (!ev_ready && n < TMO) begin
            tick();
            n++;
        end
        if (!ev_ready) check("push_timeout", 1, 0);
        tick();
        ev_valid = 1'b0;
        for (int i = 0; i < m.len(); i++) exp_q.push_back(m[i]);
        if (m.len() > 0) exp_len.push_back(m.len());
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || exp_q.size() != 0) && n < TMO) begin
            tick();
            n++;
        end
        check("idle_reached", int'(busy), 0);
        tick();
    endtask

    task automatic wait_hs(input int target);
        int n;
        n = 0;
        while (hs_total < target && n < TMO) begin
            tick();
            n++;
        end
        if (hs_total < target) check("wait_hs_timeout", hs_total, target);
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!tx_valid && n < TMO) begin
            tick();
            n++;
        end
        if (!tx_valid) check("wait_valid_timeout", 0, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int any_valid;

        rst      = 1'b1;
        ev_valid = 1'b0;
        ev_type  = 2'd0;
        ev_unit  = 2'd0;
        ev_id    = 4'd0;
        tx_ready = 1'b0;
        repeat (3) tick();
        check("rst_tx_valid", int'(tx_valid), 0);
        check("rst_tx_data", int'(tx_data), 0);
        check("rst_ev_ready", int'(ev_ready), 1);
        check("rst_busy", int'(busy), 0);
        check("rst_msg_done", int'(msg_done), 0);
        check("rst_queue_level", int'(queue_level), 0);
        check("rst_msg_count", int'(msg_count), 0);
        check("rst_rej_count", int'(rej_count), 0);
        rst = 1'b0;
        tick();

        // 1: FIM/ESU/3, latency and byte spacing
        tx_ready = 1'b1;
        base = hs_cyc.size();
        push_ev(2'd0, 2'd0, 4'd3, "FIM-ESU-3-#");
        check("t1_valid_after_event", int'(tx_valid), 0);
        tick();
        check("t1_valid_two_cycles", int'(tx_valid), 1);
        check("t1_first_byte", int'(tx_data), 8'h46);
        wait_idle();
        if (hs_cyc.size() >= base + 11) begin
            for (int k = 1; k < 11; k++) begin
                check("t1_hs_spacing", hs_cyc[base + k] - hs_cyc[base + k - 1], 3);
            end
        end else begin
            check("t1_hs_count", hs_cyc.size() - base, 11);
        end
        check("t1_msg_count", int'(msg_count), 1);

        // 2: BPM/CSU/11 then BDM/RSU/0
        push_ev(2'd1, 2'd1, 4'd11, "BPM-CSU-BB-#");
        push_ev(2'd2, 2'd2, 4'd0, "BDM-RSU-#");
        wait_idle();
        check("t2_msg_count", int'(msg_count), 3);

        // 3: stall mid-message
        base = hs_total;
        push_ev(2'd1, 2'd0, 4'd7, "BPM-ESU-B7-#");
        wait_hs(base + 4);
        wait_valid();
        tx_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_stall_valid", int'(tx_valid), 1);
            check("t3_stall_data", int'(tx_data), (exp_q.size() > 0) ? int'(exp_q[0]) : 256);
        end
        tx_ready = 1'b1;
        wait_idle();
        check("t3_msg_count", int'(msg_count), 4);

        // 4: fill the FIFO with the transmitter blocked
        tx_ready = 1'b0;
        push_ev(2'd0, 2'd0, 4'd1,  "FIM-ESU-1-#");
        push_ev(2'd1, 2'd1, 4'd2,  "BPM-CSU-B2-#");
        push_ev(2'd2, 2'd2, 4'd3,  "BDM-RSU-#");
        push_ev(2'd0, 2'd1, 4'd10, "FIM-CSU-A-#");
        push_ev(2'd1, 2'd2, 4'd15, "BPM-RSU-BF-#");
        check("t4_queue_full", int'(queue_level), 4);
        check("t4_ev_ready_low", int'(ev_ready), 0);
        check("t4_first_in_send", int'(tx_valid), 1);
        ev_valid = 1'b1;
        ev_type  = 2'd2;
        ev_unit  = 2'd0;
        ev_id    = 4'd9;
        repeat (3) tick();
        check("t4_hold_ev_ready", int'(ev_ready), 0);
        check("t4_hold_level", int'(queue_level), 4);
        tx_ready = 1'b1;
        push_ev(2'd2, 2'd0, 4'd9, "BDM-ESU-#");
        wait_idle();
        check("t4_msg_count", int'(msg_count), 10);

        // 5: reserved type/unit rejects and saturation
        any_valid = 0;
        push_ev(2'd3, 2'd0, 4'd1, "");
        any_valid |= int'(tx_valid);
        push_ev(2'd0, 2'd3, 4'd1, "");
        check("t5_rej_two", int'(rej_count), 2);
        check("t5_no_queue", int'(queue_level), 0);
        ev_valid = 1'b1;
        ev_type  = 2'd3;
        for (int k = 0; k < 300; k++) begin
            tick();
            any_valid |= int'(tx_valid);
        end
        ev_valid = 1'b0;
        ev_type  = 2'd0;
        tick();
        check("t5_rej_saturated", int'(rej_count), 255);
        check("t5_tx_never_valid", any_valid, 0);

        // 6: reset in the middle of a message with two events queued
        tx_ready = 1'b0;
        push_ev(2'd0, 2'd0, 4'd5, "FIM-ESU-5-#");
        push_ev(2'd2, 2'd1, 4'd1, "BDM-CSU-#");
        push_ev(2'd1, 2'd0, 4'd2, "BPM-ESU-B2-#");
        check("t6_queued_two", int'(queue_level), 2);
        base = hs_total;
        tx_ready = 1'b1;
        wait_hs(base + 5);
        wait_valid();
        rst      = 1'b1;
        tx_ready = 1'b0;
        exp_q.delete();
        exp_len.delete();
        tick();
        check("t6_tx_valid_dropped", int'(tx_valid), 0);
        check("t6_queue_cleared", int'(queue_level), 0);
        check("t6_msg_count_cleared", int'(msg_count), 0);
        check("t6_rej_count_cleared", int'(rej_count), 0);
        check("t6_no_msg_done", int'(msg_done), 0);
        check("t6_ev_ready", int'(ev_ready), 1);
        rst = 1'b0;
        tick();
        check("t6_no_msg_done_after", int'(msg_done), 0);
        tx_ready = 1'b1;
        push_ev(2'd0, 2'd2, 4'd15, "FIM-RSU-F-#");
        wait_idle();
        check("t6_fresh_msg_count", int'(msg_count), 1);

        check("leftover_bytes", exp_q.size(), 0);
        check("leftover_msgs", exp_len.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
